// File: rtl/reg_bank_14x16_pkg.sv
// bank_pkg: shared constants and the clear-FSM state type for reg_bank_14x16.
//   NUM_REGS : number of data registers in the bank
//   SEL_W    : width of every register index (write select, read selects)
//   MAX_IDX  : highest legal register index
package bank_pkg;

  localparam int NUM_REGS = 14;
  localparam int SEL_W    = 4;
  localparam int MAX_IDX  = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

  // Indices 14 and 15 fit in SEL_W bits but name no register.
  function automatic logic sel_valid(input logic [SEL_W-1:0] sel);
    return sel <= SEL_W'(MAX_IDX);
  endfunction

endpackage

// File: rtl/reg_bank_clr_fsm.sv
// reg_bank_clr_fsm: sequential bulk-clear engine for reg_bank_14x16.
// Walks clr_idx over 0..MAX_IDX, one register per cycle, then pulses clr_done.
//
//   state | meaning
//   IDLE  | waiting; clr_req sampled here only
//   CLEAR | register clr_idx is overwritten this cycle
//   DONE  | sequence finished; clr_done high for this one cycle
//
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   clr_req    : bulk-clear request
//   busy       : high in CLEAR and DONE
//   clr_done   : one-cycle completion pulse
//   clr_we     : clear write strobe for register clr_idx
//   clr_idx    : register currently being cleared
module reg_bank_clr_fsm
  import bank_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_req,
  output logic             busy,
  output logic             clr_done,
  output logic             clr_we,
  output logic [SEL_W-1:0] clr_idx
);

  clr_state_t       state, state_nxt;
  logic [SEL_W-1:0] idx_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = clr_idx;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt = CLEAR;
          idx_nxt   = '0;
        end
      end
      CLEAR: begin
        if (clr_idx == SEL_W'(MAX_IDX)) begin
          state_nxt = DONE;
          idx_nxt   = '0;
        end else begin
          idx_nxt = clr_idx + 1'b1;
        end
      end
      DONE: begin
        // clr_req is deliberately ignored here; a held request restarts from IDLE.
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  assign busy     = (state != IDLE);
  assign clr_done = (state == DONE);
  assign clr_we   = (state == CLEAR);

endmodule

// File: rtl/reg_bank_14x16.sv
// reg_bank_14x16: 14 x DATA_W register bank fed by a 14-output write demux.
// Stores in[wr_sel] into reg[wr_sel], offers two registered read ports with
// write-first bypass, a sequential bulk clear and a sticky write-error flag.
//
// Optional feature macro: REG_BANK_PARITY_EN (even parity per register,
// checked on read). Without it rd_par_err_a/b are constant 0.
//
// Ports:
//   clk, rst_n            : clock and asynchronous active-low reset
//   wr_en, wr_sel         : write request and destination index
//   in0..in13             : demux outputs, one per register
//   rd_sel_a/b            : read indices (14/15 read as 0)
//   rd_data_a/b           : registered read data, 1-cycle latency
//   clr_req, busy         : bulk-clear request / clear in progress
//   clr_done              : one-cycle clear completion pulse
//   wr_err, err_clr       : sticky illegal-write flag and its clear
//   rd_par_err_a/b        : registered parity error per read port
module reg_bank_14x16
  import bank_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [SEL_W-1:0]  wr_sel,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  input  logic [DATA_W-1:0] in4,
  input  logic [DATA_W-1:0] in5,
  input  logic [DATA_W-1:0] in6,
  input  logic [DATA_W-1:0] in7,
  input  logic [DATA_W-1:0] in8,
  input  logic [DATA_W-1:0] in9,
  input  logic [DATA_W-1:0] in10,
  input  logic [DATA_W-1:0] in11,
  input  logic [DATA_W-1:0] in12,
  input  logic [DATA_W-1:0] in13,
  input  logic [SEL_W-1:0]  rd_sel_a,
  input  logic [SEL_W-1:0]  rd_sel_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done,
  output logic              wr_err,
  input  logic              err_clr,
  output logic              rd_par_err_a,
  output logic              rd_par_err_b
);

  logic [DATA_W-1:0] in_arr [NUM_REGS];
  logic [DATA_W-1:0] regs   [NUM_REGS];
  logic              clr_we;
  logic [SEL_W-1:0]  clr_idx;
  logic              wr_ok, wr_bad;
  logic              byp_a, byp_b;
  logic [DATA_W-1:0] rd_nxt_a, rd_nxt_b;

  assign in_arr[0]  = in0;
  assign in_arr[1]  = in1;
  assign in_arr[2]  = in2;
  assign in_arr[3]  = in3;
  assign in_arr[4]  = in4;
  assign in_arr[5]  = in5;
  assign in_arr[6]  = in6;
  assign in_arr[7]  = in7;
  assign in_arr[8]  = in8;
  assign in_arr[9]  = in9;
  assign in_arr[10] = in10;
  assign in_arr[11] = in11;
  assign in_arr[12] = in12;
  assign in_arr[13] = in13;

  reg_bank_clr_fsm u_clr_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_done (clr_done),
    .clr_we   (clr_we),
    .clr_idx  (clr_idx)
  );

  // busy blocks writes, so clear and write never target storage in the same cycle.
  assign wr_ok  = wr_en && !busy && sel_valid(wr_sel);
  assign wr_bad = wr_en && !wr_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else begin
      if (clr_we) regs[clr_idx] <= RESET_VAL;
      if (wr_ok)  regs[wr_sel]  <= in_arr[wr_sel];
    end
  end

  // Set wins over clear when both happen in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       wr_err <= 1'b0;
    else if (wr_bad)  wr_err <= 1'b1;
    else if (err_clr) wr_err <= 1'b0;
  end

  // Bypass only covers accepted demux writes; clear writes are not forwarded.
  assign byp_a = wr_ok && (wr_sel == rd_sel_a);
  assign byp_b = wr_ok && (wr_sel == rd_sel_b);

  always_comb begin
    rd_nxt_a = '0;
    rd_nxt_b = '0;
    if (sel_valid(rd_sel_a)) rd_nxt_a = byp_a ? in_arr[wr_sel] : regs[rd_sel_a];
    if (sel_valid(rd_sel_b)) rd_nxt_b = byp_b ? in_arr[wr_sel] : regs[rd_sel_b];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else begin
      rd_data_a <= rd_nxt_a;
      rd_data_b <= rd_nxt_b;
    end
  end

`ifdef REG_BANK_PARITY_EN
  // Even parity: par[i] makes the XOR of {regs[i], par[i]} zero.
  logic par [NUM_REGS];
  logic perr_nxt_a, perr_nxt_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) par[i] <= ^RESET_VAL;
    end else begin
      if (clr_we) par[clr_idx] <= ^RESET_VAL;
      if (wr_ok)  par[wr_sel]  <= ^in_arr[wr_sel];
    end
  end

  // A bypassed read carries fresh data whose parity is correct by construction.
  always_comb begin
    perr_nxt_a = 1'b0;
    perr_nxt_b = 1'b0;
    if (sel_valid(rd_sel_a) && !byp_a) perr_nxt_a = ^{regs[rd_sel_a], par[rd_sel_a]};
    if (sel_valid(rd_sel_b) && !byp_b) perr_nxt_b = ^{regs[rd_sel_b], par[rd_sel_b]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_par_err_a <= 1'b0;
      rd_par_err_b <= 1'b0;
    end else begin
      rd_par_err_a <= perr_nxt_a;
      rd_par_err_b <= perr_nxt_b;
    end
  end
`else
  assign rd_par_err_a = 1'b0;
  assign rd_par_err_b = 1'b0;
`endif

endmodule

// File: tb/tb_reg_bank_14x16.sv
// tb_reg_bank_14x16: self-checking bench for reg_bank_14x16 against an
// array-based reference model of the bank, clear sequence and error flag.
module tb_reg_bank_14x16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en, clr_req, err_clr;
  logic [3:0]  wr_sel, rd_sel_a, rd_sel_b;
  logic [15:0] in_v [14];
  logic [15:0] rd_data_a, rd_data_b;
  logic        busy, clr_done, wr_err, rd_par_err_a, rd_par_err_b;

  // reference model
  logic [15:0] m [14];
  bit          corrupt [14];
  int          clr_pos;          // -1 idle, 0..13 clearing reg clr_pos, 14 done cycle
  logic        err_m;
  logic [15:0] exp_a, exp_b;
  logic        exp_pa, exp_pb;
  int          n_assert = 0;
  int          n_fail   = 0;
  int          busy_cnt, done_cnt;

`ifdef REG_BANK_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  reg_bank_14x16 dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel),
    .in0(in_v[0]), .in1(in_v[1]), .in2(in_v[2]), .in3(in_v[3]),
    .in4(in_v[4]), .in5(in_v[5]), .in6(in_v[6]), .in7(in_v[7]),
    .in8(in_v[8]), .in9(in_v[9]), .in10(in_v[10]), .in11(in_v[11]),
    .in12(in_v[12]), .in13(in_v[13]),
    .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .clr_req(clr_req), .busy(busy), .clr_done(clr_done),
    .wr_err(wr_err), .err_clr(err_clr),
    .rd_par_err_a(rd_par_err_a), .rd_par_err_b(rd_par_err_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 14; i++) begin m[i] = 16'h0000; corrupt[i] = 1'b0; end
    clr_pos = -1; err_m = 1'b0;
    exp_a = '0; exp_b = '0; exp_pa = 1'b0; exp_pb = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, " rd_data_a"}, 32'(rd_data_a), 32'(exp_a));
    check({tag, " rd_data_b"}, 32'(rd_data_b), 32'(exp_b));
    check({tag, " busy"},      32'(busy),      32'(clr_pos >= 0));
    check({tag, " clr_done"},  32'(clr_done),  32'(clr_pos == 14));
    check({tag, " wr_err"},    32'(wr_err),    32'(err_m));
    check({tag, " par_err_a"}, 32'(rd_par_err_a), 32'(exp_pa));
    check({tag, " par_err_b"}, 32'(rd_par_err_b), 32'(exp_pb));
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; clr_req = 1'b0; err_clr = 1'b0;
    wr_sel = 4'd0; rd_sel_a = 4'd0; rd_sel_b = 4'd0;
  endtask

  task automatic rand_ins();
    for (int i = 0; i < 14; i++) in_v[i] = 16'($urandom);
  endtask

  function automatic logic [15:0] read_val(input logic [3:0] sel, input bit acc);
    if (sel > 4'd13) return 16'h0000;
    if (acc && wr_sel == sel) return in_v[wr_sel];
    return m[sel];
  endfunction

  function automatic logic read_perr(input logic [3:0] sel, input bit acc);
    if (!PAR_EN || sel > 4'd13) return 1'b0;
    if (acc && wr_sel == sel) return 1'b0;
    return corrupt[sel];
  endfunction

  // One clock: model the edge with the inputs currently applied, then check.
  task automatic step(input string tag);
    bit acc, bad;
    @(posedge clk);
    acc = wr_en && (clr_pos < 0) && (wr_sel <= 4'd13);
    bad = wr_en && !acc;
    exp_a  = read_val(rd_sel_a, acc);
    exp_b  = read_val(rd_sel_b, acc);
    exp_pa = read_perr(rd_sel_a, acc);
    exp_pb = read_perr(rd_sel_b, acc);
    if (acc) begin m[wr_sel] = in_v[wr_sel]; corrupt[wr_sel] = 1'b0; end
    if (clr_pos >= 0 && clr_pos <= 13) begin
      m[clr_pos] = 16'h0000; corrupt[clr_pos] = 1'b0; clr_pos++;
    end else if (clr_pos == 14) begin
      clr_pos = -1;
    end else if (clr_req) begin
      clr_pos = 0;
    end
    if (bad) err_m = 1'b1;
    else if (err_clr) err_m = 1'b0;
    @(negedge clk);
    if (busy) busy_cnt++;
    if (clr_done) done_cnt++;
    check_outputs(tag);
  endtask

  initial begin
    idle_inputs();
    for (int i = 0; i < 14; i++) in_v[i] = 16'h0000;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // reset contents on every index, both ports
    for (int i = 0; i < 16; i++) begin
      rand_ins();
      rd_sel_a = 4'(i); rd_sel_b = 4'(15 - i);
      step("post_reset_read");
    end

    // write 3 with a noisy neighbour input, same-cycle bypass read
    for (int i = 0; i < 14; i++) in_v[i] = 16'h0000;
    in_v[3] = 16'hBEEF; in_v[5] = 16'h1234;
    wr_en = 1'b1; wr_sel = 4'd3; rd_sel_a = 4'd3; rd_sel_b = 4'd5;
    step("write3_bypass");
    check("bypass value", 32'(rd_data_a), 32'h0000BEEF);
    wr_en = 1'b0;
    step("write3_read");
    check("read reg3", 32'(rd_data_a), 32'h0000BEEF);
    check("read reg5", 32'(rd_data_b), 32'h00000000);

    // illegal writes and sticky error
    rand_ins();
    wr_en = 1'b1; wr_sel = 4'd14; rd_sel_a = 4'd3; rd_sel_b = 4'd13;
    step("illegal14");
    wr_en = 1'b0;
    step("err_sticky");
    wr_en = 1'b1; wr_sel = 4'd15; err_clr = 1'b1;
    step("err_set_wins");
    wr_en = 1'b0;
    step("err_clr_alone");
    err_clr = 1'b0;
    step("err_cleared");

    // fill, then clear while hammering writes
    for (int i = 0; i < 14; i++) begin
      rand_ins();
      in_v[i] = 16'h1000 + 16'(i);
      wr_en = 1'b1; wr_sel = 4'(i);
      rd_sel_a = 4'($urandom_range(0, 15)); rd_sel_b = 4'(i);
      step("fill");
    end
    wr_en = 1'b0;
    for (int i = 0; i < 14; i++) begin
      rd_sel_a = 4'(i); rd_sel_b = 4'(13 - i);
      step("fill_read");
    end
    busy_cnt = 0; done_cnt = 0;
    clr_req = 1'b1;
    step("clr_start");
    clr_req = 1'b0;
    for (int k = 0; k < 16; k++) begin
      rand_ins();
      wr_en = ($urandom_range(0, 3) != 0);
      wr_sel = 4'($urandom_range(0, 15));
      rd_sel_a = 4'($urandom_range(0, 15)); rd_sel_b = 4'($urandom_range(0, 13));
      step("during_clear");
    end
    check("busy cycles", 32'(busy_cnt), 32'd15);
    check("clr_done pulses", 32'(done_cnt), 32'd1);
    wr_en = 1'b0; err_clr = 1'b1;
    for (int i = 0; i < 14; i++) begin
      rd_sel_a = 4'(i); rd_sel_b = 4'(i);
      step("after_clear");
      err_clr = 1'b0;
    end

    // clr_req held through DONE, plus write in the same IDLE cycle as clr_req
    rand_ins();
    wr_en = 1'b1; wr_sel = 4'd9; clr_req = 1'b1; rd_sel_a = 4'd9; rd_sel_b = 4'd0;
    step("wr_with_clr");
    wr_en = 1'b0;
    for (int k = 0; k < 17; k++) begin
      rd_sel_a = 4'd9; rd_sel_b = 4'($urandom_range(0, 15));
      step("clr_held");
    end
    clr_req = 1'b0;
    for (int k = 0; k < 16; k++) step("clr_drain");

    // random traffic
    for (int k = 0; k < 400; k++) begin
      rand_ins();
      wr_en    = ($urandom_range(0, 2) != 0);
      wr_sel   = 4'($urandom_range(0, 15));
      rd_sel_a = 4'($urandom_range(0, 15));
      rd_sel_b = ($urandom_range(0, 3) == 0) ? wr_sel : 4'($urandom_range(0, 15));
      clr_req  = ($urandom_range(0, 39) == 0);
      err_clr  = ($urandom_range(0, 7) == 0);
      step("random");
    end
    idle_inputs();
    for (int k = 0; k < 16; k++) step("random_drain");

    // reset in the middle of a clear
    for (int i = 0; i < 14; i++) begin
      rand_ins();
      in_v[i] = 16'h2000 + 16'(i);
      wr_en = 1'b1; wr_sel = 4'(i); rd_sel_a = 4'(i); rd_sel_b = 4'(i);
      step("refill");
    end
    wr_en = 1'b0; wr_sel = 4'd14; wr_en = 1'b1;
    step("set_err_before_reset");
    wr_en = 1'b0;
    clr_req = 1'b1;
    rd_sel_a = 4'd10; rd_sel_b = 4'd12;
    step("clr_start2");
    clr_req = 1'b0;
    for (int k = 0; k < 6; k++) step("clr_to_idx6");
    check("model at clr_idx 6", 32'(clr_pos), 32'd6);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("mid_clear_reset");
    @(negedge clk);
    check_outputs("mid_clear_reset_hold");
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      rd_sel_a = 4'(i); rd_sel_b = 4'(13 - i);
      step("after_mid_reset");
    end

`ifdef REG_BANK_PARITY_EN
    in_v[7] = 16'h5A5A; wr_en = 1'b1; wr_sel = 4'd7;
    step("par_write7");
    wr_en = 1'b0;
    dut.regs[7][0] = ~dut.regs[7][0];
    m[7] = m[7] ^ 16'h0001;
    corrupt[7] = 1'b1;
    rd_sel_a = 4'd6; rd_sel_b = 4'd7;
    step("par_flip_read");
    check("par_err_b flagged", 32'(rd_par_err_b), 32'd1);
    rd_sel_a = 4'd7; rd_sel_b = 4'd14;
    step("par_out_of_range");
    in_v[7] = 16'h0F0F; wr_en = 1'b1; wr_sel = 4'd7; rd_sel_b = 4'd7;
    step("par_rewrite_bypass");
    wr_en = 1'b0;
    step("par_clean");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
